// File: rtl/box_map_ctrl.sv
// Destructible-box occupancy map: one bit per 16x16 tile, a registered render lookup,
// and a sequencing FSM that serves collision queries and clear requests one at a time.
module box_map_ctrl #(
  parameter int COLS = 15,
  parameter int ROWS = 11,
  parameter logic [COLS*ROWS-1:0] INIT_MAP = '0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] v_x,
  input  logic [9:0] v_y,
  output logic       box_on,
  output logic [9:0] row,
  output logic [9:0] col,
  input  logic       q_req,
  input  logic [9:0] q_x,
  input  logic [9:0] q_y,
  input  logic [1:0] q_dir,
  output logic       q_ack,
  output logic       q_blocked,
  input  logic       c_req,
  input  logic [4:0] c_col,
  input  logic [3:0] c_row,
  output logic       c_ack,
  output logic       c_hit
);

  localparam int NBITS = COLS * ROWS;
  localparam logic [6:0]  COLS_W = 7'(COLS);
  localparam logic [6:0]  ROWS_W = 7'(ROWS);
  localparam logic [15:0] COLS_M = 16'(COLS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_QA    = 3'd1,
    S_QB    = 3'd2,
    S_QDONE = 3'd3,
    S_CLR   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [NBITS-1:0] r_map;
  logic [9:0]       r_qx;
  logic [9:0]       r_qy;
  logic [1:0]       r_qdir;
  logic             r_res;
  logic             r_box_on;
  logic [9:0]       r_row;
  logic [9:0]       r_col;
  logic             r_q_ack;
  logic             r_q_blocked;
  logic             r_c_ack;
  logic             r_c_hit;

  logic [10:0]      w_x11;
  logic [10:0]      w_y11;
  logic [10:0]      w_cx;
  logic [10:0]      w_cy;
  logic             w_corner_blk;
  logic             w_render_hit;
  logic             w_c_old;
  logic [NBITS-1:0] w_clr_mask;

  function automatic logic in_range(input logic [6:0] tc, input logic [6:0] tr);
    return (tc < COLS_W) && (tr < ROWS_W);
  endfunction

  function automatic logic [15:0] tile_idx(input logic [6:0] tc, input logic [6:0] tr);
    return ({9'd0, tr} * COLS_M) + {9'd0, tc};
  endfunction

  // Out-of-range tiles read as empty; callers decide whether that means blocked.
  function automatic logic map_get(input logic [NBITS-1:0] m, input logic [6:0] tc,
                                   input logic [6:0] tr);
    logic [NBITS-1:0] sh;
    sh = m >> tile_idx(tc, tr);
    return in_range(tc, tr) && sh[0];
  endfunction

  // Select the corner pixel under test: corner A in QA, corner B otherwise.
  always_comb begin
    w_x11 = {1'b0, r_qx};
    w_y11 = {1'b0, r_qy};
    w_cx  = w_x11;
    w_cy  = w_y11;
    case (r_qdir)
      2'd0: begin
        w_cy = w_y11 - 11'd1;
        w_cx = (r_state == S_QB) ? (w_x11 + 11'd15) : w_x11;
      end
      2'd1: begin
        w_cy = w_y11 + 11'd16;
        w_cx = (r_state == S_QB) ? (w_x11 + 11'd15) : w_x11;
      end
      2'd2: begin
        w_cx = w_x11 - 11'd1;
        w_cy = (r_state == S_QB) ? (w_y11 + 11'd15) : w_y11;
      end
      2'd3: begin
        w_cx = w_x11 + 11'd16;
        w_cy = (r_state == S_QB) ? (w_y11 + 11'd15) : w_y11;
      end
      default: begin
        w_cx = w_x11;
        w_cy = w_y11;
      end
    endcase
    w_corner_blk = !in_range(7'(w_cx >> 4), 7'(w_cy >> 4)) ||
                   map_get(r_map, 7'(w_cx >> 4), 7'(w_cy >> 4));
  end

  // Render lookup and clear-target decode.
  always_comb begin
    w_render_hit = map_get(r_map, 7'(v_x >> 4), 7'(v_y >> 4));
    w_c_old      = map_get(r_map, 7'(c_col), 7'(c_row));
    if (in_range(7'(c_col), 7'(c_row))) begin
      w_clr_mask = {{(NBITS-1){1'b0}}, 1'b1} << tile_idx(7'(c_col), 7'(c_row));
    end else begin
      w_clr_mask = '0;
    end
  end

  // Next-state logic; clear wins over query only when both wait in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (c_req) begin
          w_next = S_CLR;
        end else if (q_req) begin
          w_next = S_QA;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_QA:    w_next = S_QB;
      S_QB:    w_next = S_QDONE;
      S_QDONE: w_next = S_IDLE;
      S_CLR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Query operand latch and corner-A result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_qx   <= 10'd0;
      r_qy   <= 10'd0;
      r_qdir <= 2'd0;
      r_res  <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && (w_next == S_QA)) begin
        r_qx   <= q_x;
        r_qy   <= q_y;
        r_qdir <= q_dir;
      end
      if (r_state == S_QA) begin
        r_res <= w_corner_blk;
      end
    end
  end

  // Handshake outputs, registered so they line up with the QDONE and CLR cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q_ack     <= 1'b0;
      r_q_blocked <= 1'b0;
      r_c_ack     <= 1'b0;
      r_c_hit     <= 1'b0;
    end else begin
      r_q_ack     <= (r_state == S_QB);
      r_q_blocked <= (r_state == S_QB) && (r_res || w_corner_blk);
      r_c_ack     <= (w_next == S_CLR);
      r_c_hit     <= (w_next == S_CLR) && w_c_old;
    end
  end

  // Occupancy map; bits only ever drop at the end of a CLR cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_map <= INIT_MAP;
    end else if (r_state == S_CLR) begin
      r_map <= r_map & ~w_clr_mask;
    end
  end

  // Render path, one cycle behind the pixel coordinates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_box_on <= 1'b0;
      r_row    <= 10'd0;
      r_col    <= 10'd0;
    end else begin
      r_box_on <= w_render_hit;
      r_row    <= {6'd0, v_y[3:0]};
      r_col    <= {6'd0, v_x[3:0]};
    end
  end

  assign box_on    = r_box_on;
  assign row       = r_row;
  assign col       = r_col;
  assign q_ack     = r_q_ack;
  assign q_blocked = r_q_blocked;
  assign c_ack     = r_c_ack;
  assign c_hit     = r_c_hit;

endmodule
